// File: rtl/rx_uart.sv
// -----------------------------------------------------------------------------
// rx_uart - oversampling asynchronous serial receiver (8N1-style framing)
//
// Receives one start bit, DATA_BITS data bits (LSB first) and one stop bit.
// The line is resynchronised, the start bit is confirmed at its midpoint and
// every following bit is sampled once per bit period, also near its midpoint.
// A single received byte is held until the consumer pops it with rd.
//
// Parameters
//   OVERSAMPLE  baud_tick pulses per bit period (even, >= 8)
//   DATA_BITS   data bits per frame (>= 2)
//
// Ports
//   clk          in   rising-edge clock for all logic
//   reset        in   asynchronous active-low reset
//   baud_tick    in   one-clk enable at OVERSAMPLE x baud rate
//   rx_in        in   serial line, idle high, asynchronous to clk
//   rd           in   consumer acknowledge, pops the held byte
//   rx_data      out  last delivered byte (registered)
//   rx_valid     out  rx_data holds an unread byte
//   framing_err  out  stop bit of the last completed frame was low
//   overrun      out  sticky: a byte was dropped because rx_data was unread
//   busy         out  receiver FSM is not idle
// -----------------------------------------------------------------------------
module rx_uart #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   rx_meta_r;
    logic                   rx_sync_r;
    logic                   rx_s;
    logic [CNT_W-1:0]       tick_cnt_r;
    logic [BIT_W-1:0]       bit_idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   start_sample_s;
    logic                   data_sample_s;
    logic                   stop_sample_s;
    logic                   deliver_s;

    assign rx_s = rx_sync_r;

    // Sampling strobes: the single clk cycles in which a line sample is taken.
    assign start_sample_s = baud_tick && (state_r == START) && (tick_cnt_r == HALF_LAST);
    assign data_sample_s  = baud_tick && (state_r == DATA)  && (tick_cnt_r == FULL_LAST);
    assign stop_sample_s  = baud_tick && (state_r == STOP)  && (tick_cnt_r == FULL_LAST);
    assign deliver_s      = stop_sample_s && rx_s;

    // Two-flop synchronizer; resets to the idle line level so no false start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; nothing moves without a baud_tick.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (baud_tick && !rx_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (start_sample_s) begin
                    state_next_s = rx_s ? IDLE : DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (data_sample_s && (bit_idx_r == LAST_BIT)) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (stop_sample_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output logic.
    always_comb begin
        busy = 1'b0;
        if (state_r != IDLE) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

    // Oversample tick counter and data bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= '0;
            bit_idx_r  <= '0;
        end else if (baud_tick) begin
            case (state_r)
                IDLE: begin
                    tick_cnt_r <= '0;
                    bit_idx_r  <= '0;
                end
                START: begin
                    if (tick_cnt_r == HALF_LAST) begin
                        tick_cnt_r <= '0;
                        bit_idx_r  <= '0;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_r <= '0;
                        if (bit_idx_r == LAST_BIT) begin
                            bit_idx_r <= '0;
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_r <= tick_cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_r <= '0;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    tick_cnt_r <= '0;
                    bit_idx_r  <= '0;
                end
            endcase
        end else begin
            tick_cnt_r <= tick_cnt_r;
            bit_idx_r  <= bit_idx_r;
        end
    end

    // Data shift register, filled LSB first from the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r <= '0;
        end else if (data_sample_s) begin
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Output holding register, valid/overrun handshake and framing flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (stop_sample_s) begin
                framing_err <= ~rx_s;
            end else begin
                framing_err <= framing_err;
            end

            if (deliver_s) begin
                if (!rx_valid) begin
                    rx_data  <= shift_r;
                    rx_valid <= 1'b1;
                end else if (rd) begin
                    // Held byte popped in the same cycle: replace it.
                    rx_data  <= shift_r;
                    rx_valid <= 1'b1;
                    overrun  <= 1'b0;
                end else begin
                    // Held byte still unread: keep it, drop the new one.
                    overrun  <= 1'b1;
                end
            end else if (rd && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
                overrun  <= overrun;
            end
        end
    end

endmodule

// File: tb/tb_rx_uart.sv
// -----------------------------------------------------------------------------
// tb_rx_uart - directed bench for rx_uart with a byte scoreboard.
// The stimulus process sends frames and pushes each byte it expects to be
// delivered; a monitor pops and compares whenever a new byte is presented.
// Flag and reset behaviour are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_rx_uart;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          baud_tick;
    logic          rx_in;
    logic          rd;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          framing_err;
    logic          overrun;
    logic          busy;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            tick_div = 1;
    int            cyc      = 0;
    logic [DB-1:0] exp_q[$];

    always #5 clk = ~clk;

    rx_uart #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .rd          (rd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        baud_tick = (tick_div == 1) ? 1'b1 : ((cyc % 2) == 0);
    endtask

    task automatic send_bits(input logic v, input int n);
        rx_in = v;
        repeat (n) step();
    endtask

    // Full frame; optionally pulses rd in the exact stop-sample cycle
    // (11th clock of the stop bit with baud_tick tied high).
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input bit rd_on_delivery);
        int cpb;
        cpb = OS * tick_div;
        send_bits(1'b0, cpb);
        check("busy_mid_frame", busy, 32'd1);
        for (int i = 0; i < DB; i++) begin
            send_bits(d[i], cpb);
        end
        rx_in = stop_bit;
        if (rd_on_delivery) begin
            repeat (10) step();
            rd = 1'b1;
            step();
            rd = 1'b0;
            repeat (cpb - 11) step();
        end else begin
            repeat (cpb) step();
        end
        rx_in = 1'b1;
        repeat (2 * cpb) step();
    endtask

    task automatic pop_byte();
        rd = 1'b1;
        step();
        rd = 1'b0;
        step();
    endtask

    // Monitor: a new byte is on rx_data when rx_valid rises, or stays high
    // across an edge at which rd was asserted.
    initial begin
        bit pv;
        bit pr;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 && (!pv || pr)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no delivery", rx_data);
                end else begin
                    check("rx_data_scoreboard", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            pv = (rx_valid === 1'b1);
            pr = (rd === 1'b1);
        end
    end

    initial begin
        reset     = 1'b0;
        rx_in     = 1'b1;
        rd        = 1'b0;
        baud_tick = 1'b1;
        repeat (3) step();
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", rx_valid, 32'd0);
        check("rst_framing_err", framing_err, 32'd0);
        check("rst_overrun", overrun, 32'd0);
        check("rst_busy", busy, 32'd0);
        reset = 1'b1;
        repeat (4) step();

        // Good frame 0xA5
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_valid", rx_valid, 32'd1);
        check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
        check("a5_ferr", framing_err, 32'd0);
        check("a5_busy", busy, 32'd0);
        check("a5_overrun", overrun, 32'd0);
        pop_byte();
        check("a5_pop_valid", rx_valid, 32'd0);

        // Short glitch: 4 low clocks, rejected at the start midpoint
        send_bits(1'b0, 4);
        rx_in = 1'b1;
        repeat (2) step();
        check("glitch_busy_start", busy, 32'd1);
        repeat (20) step();
        check("glitch_busy_idle", busy, 32'd0);
        check("glitch_valid", rx_valid, 32'd0);
        check("glitch_ferr", framing_err, 32'd0);
        check("glitch_overrun", overrun, 32'd0);

        // Bad stop bit 0x3C then good 0x01
        send_frame(8'h3C, 1'b0, 1'b0);
        check("bad_ferr", framing_err, 32'd1);
        check("bad_valid", rx_valid, 32'd0);
        check("bad_data_kept", {24'd0, rx_data}, 32'h0000_00A5);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0);
        check("good01_ferr", framing_err, 32'd0);
        check("good01_data", {24'd0, rx_data}, 32'h0000_0001);
        check("good01_valid", rx_valid, 32'd1);
        pop_byte();

        // Overrun: 0x11 then 0x22 without reading
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_data", {24'd0, rx_data}, 32'h0000_0011);
        check("ovr_valid", rx_valid, 32'd1);
        check("ovr_flag", overrun, 32'd1);
        pop_byte();
        check("ovr_pop_valid", rx_valid, 32'd0);
        check("ovr_pop_flag", overrun, 32'd0);

        // rd on the delivery cycle of 0x22 while 0x11 is held
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        check("rdd_data", {24'd0, rx_data}, 32'h0000_0022);
        check("rdd_valid", rx_valid, 32'd1);
        check("rdd_overrun", overrun, 32'd0);

        // Reset during data bit 4 (byte 0x22 still held)
        send_bits(1'b0, OS);
        send_bits(1'b1, OS);
        send_bits(1'b0, OS);
        send_bits(1'b1, OS);
        send_bits(1'b0, OS);
        send_bits(1'b1, OS / 2);
        check("mid_busy", busy, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_valid", rx_valid, 32'd0);
        check("mid_rst_ferr", framing_err, 32'd0);
        check("mid_rst_overrun", overrun, 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        rx_in = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        repeat (4) step();
        check("post_rst_busy", busy, 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("5a_data", {24'd0, rx_data}, 32'h0000_005A);
        check("5a_valid", rx_valid, 32'd1);
        check("5a_ferr", framing_err, 32'd0);
        pop_byte();

        // baud_tick every other clock: counters must hold between ticks
        tick_div = 2;
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 1'b0);
        check("half_data", {24'd0, rx_data}, 32'h0000_0096);
        check("half_valid", rx_valid, 32'd1);
        check("half_busy", busy, 32'd0);
        pop_byte();
        tick_div = 1;
        step();

        // rd with nothing held has no effect
        pop_byte();
        check("idle_rd_valid", rx_valid, 32'd0);
        check("idle_rd_overrun", overrun, 32'd0);
        check("idle_rd_data", {24'd0, rx_data}, 32'h0000_0096);

        repeat (4) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
